// File: rtl/fpu_rnd_result_sel_pipe.sv
// ---------------------------------------------------------------------------
// fpu_rnd_result_sel_pipe
//
// Registered rounding-result select stage. It sits between the rounding
// candidate generators and the exponent-adjust/pack stage. The stage picks one
// {ovf_rnd, mantissa} candidate word using the path select code and registers
// it into an output stage. The output stage has a valid/ready handshake and a
// one-word skid buffer, so up to two words can be held. The stage also keeps a
// saturating count of accepted words whose ovf_rnd bit is set.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset (wins over every other input)
//   in_data    NUM_IN packed candidates, candidate k at [(k+1)*(MW+1)-1 : k*(MW+1)],
//              MSB of each candidate = ovf_rnd
//   in_sel     path select code; out-of-range codes pick candidate NUM_IN-1
//   in_valid   upstream word valid
//   in_ready   stage can accept a word (registered, low while the skid is full)
//   out_mant   selected mantissa (registered)
//   out_ovf    selected ovf_rnd bit (registered)
//   out_valid  output word valid
//   out_ready  downstream accepts the output word
//   ovf_cnt    saturating count of accepted words with ovf_rnd = 1
//   cnt_clr    synchronous counter clear, beats a same-cycle increment
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module fpu_rnd_result_sel_pipe #(
   parameter int MW     = 24,
   parameter int NUM_IN = 2,
   parameter int SEL_W  = 3,
   parameter int CNT_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_IN*(MW+1)-1:0] in_data,
   input  logic [SEL_W-1:0]         in_sel,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [MW-1:0]            out_mant,
   output logic                     out_ovf,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CNT_W-1:0]         ovf_cnt,
   input  logic                     cnt_clr
);

   localparam int               WW      = MW + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Pick the candidate addressed by sel. Any code at or beyond NUM_IN falls
   // back to the last candidate, so the loop starts from that one and only
   // overrides it for the in-range codes 0 .. NUM_IN-2.
   function automatic logic [WW-1:0] pick_word(
      input logic [NUM_IN*WW-1:0] data,
      input logic [SEL_W-1:0]     sel
   );
      logic [WW-1:0] w;
      w = data[(NUM_IN-1)*WW +: WW];
      for (int k = 0; k < NUM_IN - 1; k++) begin
         w = (int'(sel) == k) ? data[k*WW +: WW] : w;
      end
      return w;
   endfunction

   logic [WW-1:0]    sel_word_s;
   logic             accept_s;
   logic             emit_s;

   logic [WW-1:0]    out_word_r;
   logic [WW-1:0]    out_word_nxt_s;
   logic             out_valid_r;
   logic             out_valid_nxt_s;

   logic [WW-1:0]    skid_word_r;
   logic [WW-1:0]    skid_word_nxt_s;
   logic             skid_valid_r;
   logic             skid_valid_nxt_s;

   logic             in_ready_r;

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;

   // Combinational candidate select ahead of the registers (pure bit routing).
   always_comb begin
      sel_word_s = pick_word(in_data, in_sel);
   end

   assign accept_s = in_valid & in_ready_r;
   assign emit_s   = out_valid_r & out_ready;

   // Next state of the output register and skid buffer. The skid word always
   // drains first, which keeps the data strictly in order. Accept together
   // with emit while the skid is full cannot occur because in_ready is low.
   always_comb begin
      out_word_nxt_s   = out_word_r;
      out_valid_nxt_s  = out_valid_r;
      skid_word_nxt_s  = skid_word_r;
      skid_valid_nxt_s = skid_valid_r;
      if (emit_s) begin
         if (skid_valid_r) begin
            out_word_nxt_s   = skid_word_r;
            out_valid_nxt_s  = 1'b1;
            skid_valid_nxt_s = 1'b0;
         end else if (accept_s) begin
            out_word_nxt_s  = sel_word_s;
            out_valid_nxt_s = 1'b1;
         end else begin
            out_valid_nxt_s = 1'b0;
         end
      end else begin
         if (!out_valid_r) begin
            if (accept_s) begin
               out_word_nxt_s  = sel_word_s;
               out_valid_nxt_s = 1'b1;
            end else begin
               out_valid_nxt_s = 1'b0;
            end
         end else if (accept_s) begin
            // The output is stalled, so park the new word in the skid.
            skid_word_nxt_s  = sel_word_s;
            skid_valid_nxt_s = 1'b1;
         end else begin
            skid_valid_nxt_s = skid_valid_r;
         end
      end
   end

   // Next value of the overflow event counter. The clear wins, and the count
   // sticks at all-ones instead of wrapping.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (cnt_clr) begin
         cnt_nxt_s = {CNT_W{1'b0}};
      end else if (accept_s && sel_word_s[MW] && (cnt_r != CNT_MAX)) begin
         cnt_nxt_s = cnt_r + CNT_W'(1);
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // State registers. Reset drops any held words and nothing is replayed.
   // in_ready is registered from the next skid occupancy so that it always
   // equals !skid_valid without a combinational path from out_ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_word_r   <= {WW{1'b0}};
         out_valid_r  <= 1'b0;
         skid_word_r  <= {WW{1'b0}};
         skid_valid_r <= 1'b0;
         in_ready_r   <= 1'b1;
         cnt_r        <= {CNT_W{1'b0}};
      end else begin
         out_word_r   <= out_word_nxt_s;
         out_valid_r  <= out_valid_nxt_s;
         skid_word_r  <= skid_word_nxt_s;
         skid_valid_r <= skid_valid_nxt_s;
         in_ready_r   <= ~skid_valid_nxt_s;
         cnt_r        <= cnt_nxt_s;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_mant  = out_word_r[MW-1:0];
   assign out_ovf   = out_word_r[MW];
   assign ovf_cnt   = cnt_r;

   fpu_rnd_result_sel_pipe_chk #(
      .WW (WW)
   ) u_chk (
      .clk        (clk),
      .rst        (rst),
      .out_valid  (out_valid_r),
      .out_ready  (out_ready),
      .skid_valid (skid_valid_r),
      .in_ready   (in_ready_r),
      .out_word   (out_word_r)
   );

endmodule

// ---------------------------------------------------------------------------
// fpu_rnd_result_sel_pipe_chk
//
// Property checker for the select pipe's handshake invariants.
// Ports: clk, rst, out_valid, out_ready, skid_valid, in_ready and out_word are
// all observed copies of the pipe's state and handshake signals.
// ---------------------------------------------------------------------------
module fpu_rnd_result_sel_pipe_chk #(
   parameter int WW = 25
) (
   input logic          clk,
   input logic          rst,
   input logic          out_valid,
   input logic          out_ready,
   input logic          skid_valid,
   input logic          in_ready,
   input logic [WW-1:0] out_word
);

   // A stalled output word must neither change nor disappear.
   property p_hold;
      @(posedge clk) disable iff (rst)
         (out_valid && !out_ready) |=> (out_valid && $stable(out_word));
   endproperty
   a_hold: assert property (p_hold);

   // A full skid implies a full output register and back-pressure upstream.
   property p_skid;
      @(posedge clk) disable iff (rst)
         skid_valid |-> (out_valid && !in_ready);
   endproperty
   a_skid: assert property (p_skid);

endmodule

// File: tb/tb_fpu_rnd_result_sel_pipe.sv
`timescale 1ns/1ps

module tb_fpu_rnd_result_sel_pipe;

   localparam int MW      = 24;
   localparam int WW      = MW + 1;
   localparam int NUM_IN  = 2;
   localparam int SEL_W   = 3;
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic                 clk = 1'b0;
   logic                 rst;

   // main instance (defaults)
   logic [WW-1:0]        cand [NUM_IN];
   logic [NUM_IN*WW-1:0] in_data;
   logic [SEL_W-1:0]     in_sel;
   logic                 in_valid, in_ready, out_ovf, out_valid, out_ready, cnt_clr;
   logic [MW-1:0]        out_mant;
   logic [CNT_W-1:0]     ovf_cnt;

   // NUM_IN = 4 instance
   logic [WW-1:0]        cand4 [4];
   logic [4*WW-1:0]      in_data4;
   logic [SEL_W-1:0]     in_sel4;
   logic                 in_valid4, in_ready4, out_ovf4, out_valid4;
   logic [MW-1:0]        out_mant4;
   logic [CNT_W-1:0]     ovf_cnt4;

   // CNT_W = 2 instance (shares in_data / in_sel with the main instance)
   logic                 in_valid2, cnt_clr2, in_ready2, out_ovf2, out_valid2;
   logic [MW-1:0]        out_mant2;
   logic [1:0]           ovf_cnt2;

   int n_checks = 0;
   int n_pass   = 0;
   int dut_emits = 0;
   bit chk_en   = 1'b0;
   int exp_sat [5] = '{1, 2, 3, 3, 3};

   // reference model state: words held by the stage, oldest first
   logic [WW-1:0] mq [$];
   int            m_cnt = 0;

   always #5 clk = ~clk;

   always_comb begin
      in_data = '0;
      for (int k = 0; k < NUM_IN; k++) in_data[k*WW +: WW] = cand[k];
   end

   always_comb begin
      in_data4 = '0;
      for (int k = 0; k < 4; k++) in_data4[k*WW +: WW] = cand4[k];
   end

   fpu_rnd_result_sel_pipe #(.MW(MW), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
      .in_ready(in_ready), .out_mant(out_mant), .out_ovf(out_ovf), .out_valid(out_valid),
      .out_ready(out_ready), .ovf_cnt(ovf_cnt), .cnt_clr(cnt_clr));

   fpu_rnd_result_sel_pipe #(.MW(MW), .NUM_IN(4), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut4 (
      .clk(clk), .rst(rst), .in_data(in_data4), .in_sel(in_sel4), .in_valid(in_valid4),
      .in_ready(in_ready4), .out_mant(out_mant4), .out_ovf(out_ovf4), .out_valid(out_valid4),
      .out_ready(1'b1), .ovf_cnt(ovf_cnt4), .cnt_clr(1'b0));

   fpu_rnd_result_sel_pipe #(.MW(MW), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid2),
      .in_ready(in_ready2), .out_mant(out_mant2), .out_ovf(out_ovf2), .out_valid(out_valid2),
      .out_ready(1'b1), .ovf_cnt(ovf_cnt2), .cnt_clr(cnt_clr2));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, req);
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [WW-1:0] model_pick(input int sel);
      return cand[(sel < NUM_IN) ? sel : NUM_IN - 1];
   endfunction

   // Reference model: a two-deep FIFO; the head is the output word.
   always @(posedge clk) begin : model
      logic [WW-1:0] w;
      bit acc, emt;
      if (rst) begin
         mq.delete();
         m_cnt = 0;
      end else begin
         w   = model_pick(int'(in_sel));
         acc = in_valid && (mq.size() < 2);
         emt = (mq.size() > 0) && out_ready;
         if (emt) void'(mq.pop_front());
         if (acc) mq.push_back(w);
         if (cnt_clr) m_cnt = 0;
         else if (acc && w[MW]) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      end
   end

   // Compare the main instance against the model every cycle.
   always @(negedge clk) begin : compare
      if (chk_en) begin
         check("m_in_ready", 64'(in_ready), 64'(mq.size() < 2));
         check("m_out_valid", 64'(out_valid), 64'(mq.size() > 0));
         if (mq.size() > 0) check("m_out_word", 64'({out_ovf, out_mant}), 64'(mq[0]));
         check("m_ovf_cnt", 64'(ovf_cnt), 64'(m_cnt));
         if (out_valid && out_ready) dut_emits++;
      end
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sel = '0; out_ready = 1'b1; cnt_clr = 1'b0;
      cand[0] = '0; cand[1] = '0;
      in_valid4 = 1'b0; in_sel4 = '0;
      for (int k = 0; k < 4; k++) cand4[k] = '0;
      in_valid2 = 1'b0; cnt_clr2 = 1'b0;
      repeat (3) cyc();

      // reset state
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_mant", 64'(out_mant), 64'd0);
      check("rst_out_ovf", 64'(out_ovf), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
      rst = 1'b0;
      chk_en = 1'b1;

      // sel = 0 picks candidate 0, one-cycle latency
      cand[0] = {1'b0, 24'h800001};
      cand[1] = {1'b1, 24'h400000};
      in_sel = 3'd0; in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      check("sel0_valid", 64'(out_valid), 64'd1);
      check("sel0_mant", 64'(out_mant), 64'h800001);
      check("sel0_ovf", 64'(out_ovf), 64'd0);
      check("sel0_cnt", 64'(ovf_cnt), 64'd0);
      cyc();

      // out-of-range sel picks the last candidate
      in_sel = 3'd5; in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      check("sel5_mant", 64'(out_mant), 64'h400000);
      check("sel5_ovf", 64'(out_ovf), 64'd1);
      check("sel5_cnt", 64'(ovf_cnt), 64'd1);
      cyc();

      // four-candidate instance
      cand4[0] = {1'b0, 24'h111111};
      cand4[1] = {1'b1, 24'h222222};
      cand4[2] = {1'b0, 24'h333333};
      cand4[3] = {1'b1, 24'h444444};
      in_valid4 = 1'b1; in_sel4 = 3'd2;
      cyc();
      check("n4_sel2_mant", 64'(out_mant4), 64'h333333);
      check("n4_sel2_cnt", 64'(ovf_cnt4), 64'd0);
      in_sel4 = 3'd7;
      cyc();
      check("n4_sel7_mant", 64'(out_mant4), 64'h444444);
      check("n4_sel7_ovf", 64'(out_ovf4), 64'd1);
      check("n4_sel7_cnt", 64'(ovf_cnt4), 64'd1);
      in_sel4 = 3'd1;
      cyc();
      check("n4_sel1_mant", 64'(out_mant4), 64'h222222);
      check("n4_sel1_cnt", 64'(ovf_cnt4), 64'd2);
      in_valid4 = 1'b0;
      cyc();
      check("n4_drained", 64'(out_valid4), 64'd0);

      // back-pressure: A in output, B in skid, C stalled
      out_ready = 1'b0; in_sel = 3'd0; in_valid = 1'b1;
      cand[0] = {1'b0, 24'hAAAAAA};
      cyc();
      check("bp_a_mant", 64'(out_mant), 64'hAAAAAA);
      check("bp_a_ready", 64'(in_ready), 64'd1);
      cand[0] = {1'b0, 24'hBBBBBB};
      cyc();
      check("bp_b_ready", 64'(in_ready), 64'd0);
      cand[0] = {1'b1, 24'hCCCCCC};
      cyc();
      check("bp_hold_a", 64'(out_mant), 64'hAAAAAA);
      check("bp_c_stall", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      cyc();
      check("bp_out_b", 64'(out_mant), 64'hBBBBBB);
      check("bp_ready_back", 64'(in_ready), 64'd1);
      cyc();
      in_valid = 1'b0;
      check("bp_out_c", 64'(out_mant), 64'hCCCCCC);
      check("bp_c_ovf", 64'(out_ovf), 64'd1);
      cyc();
      check("bp_empty", 64'(out_valid), 64'd0);

      // 100-word stream at full rate
      dut_emits = 0;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         cand[0] = WW'($urandom); cand[1] = WW'($urandom);
         in_sel = SEL_W'($urandom);
         cyc();
         check("stream_valid", 64'(out_valid), 64'd1);
         check("stream_ready", 64'(in_ready), 64'd1);
      end
      in_valid = 1'b0;
      cyc();
      check("stream_count", 64'(dut_emits), 64'd100);
      check("stream_done", 64'(out_valid), 64'd0);

      // two-bit counter saturation and clear priority
      cand[1] = {1'b1, 24'h00ABCD}; in_sel = 3'd1; in_valid2 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("sat_cnt", 64'(ovf_cnt2), 64'(exp_sat[i]));
      end
      cnt_clr2 = 1'b1;
      cyc();
      check("sat_clr", 64'(ovf_cnt2), 64'd0);
      cnt_clr2 = 1'b0; in_valid2 = 1'b0;
      cyc();

      // reset with both slots full drops the held words
      out_ready = 1'b0; in_sel = 3'd1; in_valid = 1'b1;
      cand[1] = {1'b1, 24'h123456};
      cyc();
      cand[1] = {1'b1, 24'h654321};
      cyc();
      in_valid = 1'b0;
      check("prerst_valid", 64'(out_valid), 64'd1);
      check("prerst_full", 64'(in_ready), 64'd0);
      check("prerst_cnt_nz", 64'(ovf_cnt != '0), 64'd1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("midrst_valid", 64'(out_valid), 64'd0);
      check("midrst_ready", 64'(in_ready), 64'd1);
      check("midrst_cnt", 64'(ovf_cnt), 64'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("midrst_no_replay", 64'(out_valid), 64'd0);
      end

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         cand[0]   = WW'($urandom);
         cand[1]   = WW'($urandom);
         in_sel    = SEL_W'($urandom);
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 3) != 0;
         cnt_clr   = ($urandom % 32) == 0;
         rst       = ($urandom % 250) == 0;
         cyc();
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
      repeat (4) cyc();
      check("final_empty", 64'(out_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
